// File: rtl/pcie_phy_pkg.sv
// Shared PHY constants and types for the LTSSM receive path: ordered-set symbols,
// training-set header layout and the per-lane collector state encoding.
package pcie_phy_pkg;

  localparam logic [7:0]  COM_SYM  = 8'hBC;
  localparam logic [7:0]  TS1_ID   = 8'h4A;
  localparam logic [7:0]  TS2_ID   = 8'h45;
  localparam int unsigned TS_WORDS = 4;

  // Symbols 1..5 of a TS, symbol 1 in the most significant byte.
  typedef struct packed {
    logic [7:0] link_num;
    logic [7:0] lane_num;
    logic [7:0] n_fts;
    logic [7:0] rate_id;
    logic [7:0] train_ctrl;
  } ts_hdr_t;

  typedef enum logic {StHunt, StCollect} lane_state_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/ltssm_ts_lane_checker.sv
// One lane's TS collector: frames 16-symbol ordered sets on COM, classifies TS1/TS2 and
// counts consecutive identical sets into registered satisfied flags.
module ltssm_ts_lane_checker
  import pcie_phy_pkg::*;
#(
  parameter int unsigned TS_CONSEC_REQ = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [31:0] tdata_i,
  input  logic [3:0]  tuser_i,
  input  logic        tvalid_i,
  output logic        ts1_sat_o,
  output logic        ts2_sat_o,
  output logic        locked_o
);

  lane_state_e       state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [2:0][31:0]  word_q, word_d;
  logic [2:0][3:0]   kflag_q, kflag_d;
  ts_hdr_t           ref_hdr_q, ref_hdr_d;
  logic              ref_ts2_q, ref_ts2_d;
  logic              ref_valid_q, ref_valid_d;
  logic [3:0]        any_cnt_q, any_cnt_d;
  logic [3:0]        ts2_cnt_q, ts2_cnt_d;
  logic              ts1_sat_q, ts1_sat_d;
  logic              ts2_sat_q, ts2_sat_d;
  logic              locked_q, locked_d;

  logic [127:0] set_data;
  logic [15:0]  set_k;
  logic         com_start, os_is_k, set_done;
  logic         is_ts1, is_ts2, set_valid, identical;
  ts_hdr_t      cur_hdr;

  // Set being completed: three stored words plus the word arriving now.
  assign set_data  = {tdata_i, word_q[2], word_q[1], word_q[0]};
  assign set_k     = {tuser_i, kflag_q[2], kflag_q[1], kflag_q[0]};
  assign com_start = tvalid_i && tuser_i[0] && (tdata_i[7:0] == COM_SYM);
  assign os_is_k   = tuser_i[1];
  assign cur_hdr   = ts_hdr_t'({set_data[15:8], set_data[23:16], set_data[31:24],
                                set_data[39:32], set_data[47:40]});

  always_comb begin
    is_ts1 = 1'b1;
    is_ts2 = 1'b1;
    for (int s = 6; s < 16; s++) begin
      if (set_data[8*s +: 8] != TS1_ID) is_ts1 = 1'b0;
      if (set_data[8*s +: 8] != TS2_ID) is_ts2 = 1'b0;
    end
  end

  assign set_valid = (is_ts1 || is_ts2) && (set_k[15:1] == 15'd0) && set_k[0] &&
                     (set_data[7:0] == COM_SYM);
  assign identical = ref_valid_q && (cur_hdr == ref_hdr_q) && (is_ts2 == ref_ts2_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    kflag_d     = kflag_q;
    ref_hdr_d   = ref_hdr_q;
    ref_ts2_d   = ref_ts2_q;
    ref_valid_d = ref_valid_q;
    any_cnt_d   = any_cnt_q;
    ts2_cnt_d   = ts2_cnt_q;
    locked_d    = locked_q;
    set_done    = 1'b0;

    unique case (state_q)
      StHunt: begin
        // COM followed by a K-symbol is SKP/FTS/IDL: not a training set.
        if (com_start && !os_is_k) begin
          word_d[0]  = tdata_i;
          kflag_d[0] = tuser_i;
          idx_d      = 2'd1;
          state_d    = StCollect;
          locked_d   = 1'b1;
        end
      end
      StCollect: begin
        if (com_start) begin
          // Resync: partial set discarded and the consecutive run broken.
          any_cnt_d   = 4'd0;
          ts2_cnt_d   = 4'd0;
          ref_valid_d = 1'b0;
          if (os_is_k) begin
            state_d = StHunt;
            idx_d   = 2'd0;
          end else begin
            word_d[0]  = tdata_i;
            kflag_d[0] = tuser_i;
            idx_d      = 2'd1;
          end
        end else if (tvalid_i) begin
          if (idx_q == 2'(TS_WORDS - 1)) begin
            set_done = 1'b1;
            state_d  = StHunt;
            idx_d    = 2'd0;
          end else begin
            word_d[idx_q]  = tdata_i;
            kflag_d[idx_q] = tuser_i;
            idx_d          = idx_q + 2'd1;
          end
        end
      end
      default: state_d = StHunt;
    endcase

    if (set_done) begin
      if (set_valid) begin
        any_cnt_d   = identical ? sat_inc4(any_cnt_q) : 4'd1;
        ts2_cnt_d   = !is_ts2 ? 4'd0 : (identical ? sat_inc4(ts2_cnt_q) : 4'd1);
        ref_hdr_d   = cur_hdr;
        ref_ts2_d   = is_ts2;
        ref_valid_d = 1'b1;
      end else begin
        any_cnt_d   = 4'd0;
        ts2_cnt_d   = 4'd0;
        ref_valid_d = 1'b0;
      end
    end

    if (clear_i) begin
      state_d     = StHunt;
      idx_d       = 2'd0;
      ref_hdr_d   = '0;
      ref_ts2_d   = 1'b0;
      ref_valid_d = 1'b0;
      any_cnt_d   = 4'd0;
      ts2_cnt_d   = 4'd0;
      locked_d    = 1'b0;
    end

    ts1_sat_d = (any_cnt_d >= 4'(TS_CONSEC_REQ));
    ts2_sat_d = (ts2_cnt_d >= 4'(TS_CONSEC_REQ));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StHunt;
      idx_q       <= 2'd0;
      word_q      <= '0;
      kflag_q     <= '0;
      ref_hdr_q   <= '0;
      ref_ts2_q   <= 1'b0;
      ref_valid_q <= 1'b0;
      any_cnt_q   <= 4'd0;
      ts2_cnt_q   <= 4'd0;
      ts1_sat_q   <= 1'b0;
      ts2_sat_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      kflag_q     <= kflag_d;
      ref_hdr_q   <= ref_hdr_d;
      ref_ts2_q   <= ref_ts2_d;
      ref_valid_q <= ref_valid_d;
      any_cnt_q   <= any_cnt_d;
      ts2_cnt_q   <= ts2_cnt_d;
      ts1_sat_q   <= ts1_sat_d;
      ts2_sat_q   <= ts2_sat_d;
      locked_q    <= locked_d;
    end
  end

  assign ts1_sat_o = ts1_sat_q;
  assign ts2_sat_o = ts2_sat_q;
  assign locked_o  = locked_q;

endmodule

// File: rtl/ltssm_ts_rx_checker.sv
// Receive-side TS checker for the LTSSM polling substates: one independent lane checker
// per lane; the receive path never back-pressures.
module ltssm_ts_rx_checker
  import pcie_phy_pkg::*;
#(
  parameter int unsigned MAX_NUM_LANES = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TS_CONSEC_REQ = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [MAX_NUM_LANES*4-1:0]          s_axis_tuser_i,
  input  logic [MAX_NUM_LANES-1:0]            s_axis_tvalid_i,
  output logic                                s_axis_tready_o,
  output logic [MAX_NUM_LANES-1:0]            lanes_ts1_satisfied_o,
  output logic [MAX_NUM_LANES-1:0]            lanes_ts2_satisfied_o,
  output logic [MAX_NUM_LANES-1:0]            lane_locked_o
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("ltssm_ts_rx_checker: DATA_WIDTH must be 32");
  end
  if (TS_CONSEC_REQ < 1 || TS_CONSEC_REQ > 15) begin : g_bad_req
    $error("ltssm_ts_rx_checker: TS_CONSEC_REQ must be in 1..15");
  end

  logic ready_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  assign s_axis_tready_o = ready_q;

  for (genvar n = 0; n < MAX_NUM_LANES; n++) begin : g_lane
    ltssm_ts_lane_checker #(
      .TS_CONSEC_REQ(TS_CONSEC_REQ)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .tdata_i  (s_axis_tdata_i[DATA_WIDTH*n +: 32]),
      .tuser_i  (s_axis_tuser_i[4*n +: 4]),
      .tvalid_i (s_axis_tvalid_i[n]),
      .ts1_sat_o(lanes_ts1_satisfied_o[n]),
      .ts2_sat_o(lanes_ts2_satisfied_o[n]),
      .locked_o (lane_locked_o[n])
    );
  end

endmodule
